// File: rtl/baw_main.sv
// baw_main: Black-and-White card game controller.
// Edge-detects the five buttons, runs the round/turn/match FSM, keeps the
// round/win/lose scores and drives the scanned 4-digit display and status LEDs.
module baw_main #(
   parameter int unsigned REFRESH_BITS = 17,
   parameter int unsigned WIN_TARGET   = 5,
   parameter int unsigned MAX_ROUND    = 9
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        btnCenter,
   input  logic        btnTop,
   input  logic        btnBottom,
   input  logic        btnLeft,
   input  logic        btnRight,
   input  logic [15:0] sw,
   output logic [0:3]  ssSel,
   output logic [7:0]  ssDisp,
   output logic [15:0] led
);

   typedef enum logic [2:0] {
      S_INIT,
      S_RASP,
      S_BAWP,
      S_P1_TURN,
      S_P2_TURN,
      S_MATCH,
      S_GAME
   } state_t;

   // Display symbol codes: 0..15 are hex digits, then blank and dash
   localparam logic [4:0] SYM_BLANK = 5'd16;
   localparam logic [4:0] SYM_DASH  = 5'd17;
   localparam logic [3:0] WIN_LIM   = WIN_TARGET[3:0];
   localparam logic [3:0] ROUND_LIM = MAX_ROUND[3:0];

   // Button vector bit positions, highest priority first
   localparam int unsigned B_C = 4;
   localparam int unsigned B_T = 3;
   localparam int unsigned B_L = 2;
   localparam int unsigned B_R = 1;
   localparam int unsigned B_B = 0;

   state_t                  state_q, state_d;
   logic [4:0]              btn_q, btn_d;
   logic [3:0]              p1_hand_q, p1_hand_d, p2_hand_q, p2_hand_d;
   logic [8:0]              p1_used_q, p1_used_d, p2_used_q, p2_used_d;
   logic                    p1_lock_q, p1_lock_d, p2_lock_q, p2_lock_d;
   logic                    upd_q, upd_d;
   logic [1:0]              match_q, match_d;
   logic [3:0]              round_q, round_d, win_q, win_d, lose_q, lose_d;
   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

   logic [4:0] press, pick;
   logic       sel_onehot;
   logic [3:0] sel_card;
   logic [1:0] cmp;
   logic       fin;
   logic       sw_unused;
   logic [1:0] dig_sel;
   logic [4:0] d0, d1, d2, d3, sym;

   assign sw_unused = ^sw[6:0];

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [7:0] seg_of(input logic [4:0] s);
      logic [7:0] r;
      case (s)
         5'd0:    r = 8'hC0;
         5'd1:    r = 8'hF9;
         5'd2:    r = 8'hA4;
         5'd3:    r = 8'hB0;
         5'd4:    r = 8'h99;
         5'd5:    r = 8'h92;
         5'd6:    r = 8'h82;
         5'd7:    r = 8'hF8;
         5'd8:    r = 8'h80;
         5'd9:    r = 8'h90;
         5'd10:   r = 8'h88;
         5'd11:   r = 8'h83;
         5'd12:   r = 8'hC6;
         5'd13:   r = 8'hA1;
         5'd14:   r = 8'h86;
         5'd15:   r = 8'h8E;
         SYM_DASH: r = 8'hBF;
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

   // Press pulses, reduced to the single highest-priority press this cycle
   always_comb begin
      btn_d = {btnCenter, btnTop, btnLeft, btnRight, btnBottom};
      press = btn_d & ~btn_q;
      pick  = '0;
      if      (press[B_C]) pick[B_C] = 1'b1;
      else if (press[B_T]) pick[B_T] = 1'b1;
      else if (press[B_L]) pick[B_L] = 1'b1;
      else if (press[B_R]) pick[B_R] = 1'b1;
      else if (press[B_B]) pick[B_B] = 1'b1;
   end

   // Card select decode from the one-hot switch field
   always_comb begin
      sel_onehot = $onehot(sw[15:7]);
      sel_card   = '0;
      for (int unsigned k = 0; k < 9; k++) begin
         if (sw[7+k]) sel_card = k[3:0];
      end
   end

   // Round comparator and end-of-game condition
   always_comb begin
      if (p1_hand_q > p2_hand_q)      cmp = 2'b01;
      else if (p2_hand_q > p1_hand_q) cmp = 2'b10;
      else                            cmp = 2'b00;
   end

   assign fin = (win_q >= WIN_LIM) | (lose_q >= WIN_LIM) | (round_q >= ROUND_LIM);

   // Game FSM, hands, locks and score next-state
   always_comb begin
      state_d   = state_q;
      p1_hand_d = p1_hand_q;
      p2_hand_d = p2_hand_q;
      p1_used_d = p1_used_q;
      p2_used_d = p2_used_q;
      p1_lock_d = p1_lock_q;
      p2_lock_d = p2_lock_q;
      upd_d     = 1'b0;
      match_d   = match_q;
      round_d   = round_q;
      win_d     = win_q;
      lose_d    = lose_q;
      refresh_d = refresh_q + 1'b1;
      case (state_q)
         S_INIT: begin
            if (pick[B_C]) state_d = S_RASP;
         end
         S_RASP: begin
            if (pick[B_T]) begin
               state_d   = S_BAWP;
               p1_lock_d = 1'b0;
               p2_lock_d = 1'b0;
            end
         end
         S_BAWP: begin
            if (pick[B_C]) begin
               if (p1_lock_q && p2_lock_q) begin
                  state_d = S_MATCH;
                  match_d = cmp;
                  upd_d   = 1'b1;
               end
            end else if (pick[B_L]) begin
               if (!p1_lock_q) state_d = S_P1_TURN;
            end else if (pick[B_R]) begin
               if (!p2_lock_q) state_d = S_P2_TURN;
            end
         end
         S_P1_TURN: begin
            if (pick[B_T] && sel_onehot && |(sw[15:7] & ~p1_used_q)) begin
               p1_hand_d = sel_card;
               p1_used_d = p1_used_q | sw[15:7];
               p1_lock_d = 1'b1;
               state_d   = S_BAWP;
            end
         end
         S_P2_TURN: begin
            if (pick[B_T] && sel_onehot && |(sw[15:7] & ~p2_used_q)) begin
               p2_hand_d = sel_card;
               p2_used_d = p2_used_q | sw[15:7];
               p2_lock_d = 1'b1;
               state_d   = S_BAWP;
            end
         end
         S_MATCH: begin
            // fin is stale during the score-update cycle, so leaving waits one cycle
            if (upd_q) begin
               round_d = sat_inc(round_q);
               if (match_q == 2'b01) win_d  = sat_inc(win_q);
               if (match_q == 2'b10) lose_d = sat_inc(lose_q);
            end else if (pick[B_L]) begin
               state_d = fin ? S_GAME : S_RASP;
            end
         end
         S_GAME: begin
            if (pick[B_B]) begin
               state_d   = S_INIT;
               round_d   = '0;
               win_d     = '0;
               lose_d    = '0;
               p1_hand_d = '0;
               p2_hand_d = '0;
               p1_used_d = '0;
               p2_used_d = '0;
               p1_lock_d = 1'b0;
               p2_lock_d = 1'b0;
               match_d   = '0;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // All state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_INIT;
         btn_q     <= '0;
         p1_hand_q <= '0;
         p2_hand_q <= '0;
         p1_used_q <= '0;
         p2_used_q <= '0;
         p1_lock_q <= 1'b0;
         p2_lock_q <= 1'b0;
         upd_q     <= 1'b0;
         match_q   <= '0;
         round_q   <= '0;
         win_q     <= '0;
         lose_q    <= '0;
         refresh_q <= '0;
      end else begin
         state_q   <= state_d;
         btn_q     <= btn_d;
         p1_hand_q <= p1_hand_d;
         p2_hand_q <= p2_hand_d;
         p1_used_q <= p1_used_d;
         p2_used_q <= p2_used_d;
         p1_lock_q <= p1_lock_d;
         p2_lock_q <= p2_lock_d;
         upd_q     <= upd_d;
         match_q   <= match_d;
         round_q   <= round_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
         refresh_q <= refresh_d;
      end
   end

   // Per-state digit contents and scanned segment/enable outputs
   always_comb begin
      d0 = SYM_BLANK;
      d1 = SYM_BLANK;
      d2 = SYM_BLANK;
      d3 = SYM_BLANK;
      case (state_q)
         S_INIT: begin
            d0 = SYM_DASH;
            d1 = SYM_DASH;
            d2 = SYM_DASH;
            d3 = SYM_DASH;
         end
         S_RASP, S_BAWP: begin
            d0 = {1'b0, round_q};
            d2 = {1'b0, win_q};
            d3 = {1'b0, lose_q};
         end
         S_P1_TURN, S_P2_TURN: begin
            d0 = (state_q == S_P1_TURN) ? 5'd1 : 5'd2;
            d3 = sel_onehot ? {1'b0, sel_card} : SYM_DASH;
         end
         S_MATCH: begin
            case (match_q)
               2'b01:   d0 = 5'd1;
               2'b10:   d0 = 5'd2;
               default: d0 = 5'd0;
            endcase
         end
         S_GAME: begin
            if (win_q > lose_q)      d0 = 5'd1;
            else if (lose_q > win_q) d0 = 5'd2;
            else                     d0 = 5'd0;
            d2 = {1'b0, win_q};
            d3 = {1'b0, lose_q};
         end
         default: d0 = SYM_BLANK;
      endcase
      dig_sel = refresh_q[REFRESH_BITS-1 -: 2];
      case (dig_sel)
         2'd0:    sym = d0;
         2'd1:    sym = d1;
         2'd2:    sym = d2;
         default: sym = d3;
      endcase
      ssSel          = '1;
      ssSel[dig_sel] = 1'b0;
      ssDisp         = seg_of(sym);
   end

   // Status LEDs: unused cards of the active player, card colours, fin
   always_comb begin
      led = '0;
      if (state_q == S_P1_TURN)      led[15:7] = ~p1_used_q;
      else if (state_q == S_P2_TURN) led[15:7] = ~p2_used_q;
      led[2] = p2_lock_q & p2_hand_q[0];
      led[1] = p1_lock_q & p1_hand_q[0];
      led[0] = fin;
   end

endmodule

// File: tb/tb_baw_main.sv
// Self-checking bench for baw_main: vector table plus scripted game sequences,
// expected screens queued on stimulus and compared after a full display scan.
module tb_baw_main;

   logic        clk = 1'b0;
   logic        resetn;
   logic        btnCenter, btnTop, btnBottom, btnLeft, btnRight;
   logic [15:0] sw;
   logic [0:3]  ssSel;
   logic [7:0]  ssDisp;
   logic [15:0] led;

   baw_main #(.REFRESH_BITS(4), .WIN_TARGET(5), .MAX_ROUND(9)) dut (
      .clk(clk), .resetn(resetn),
      .btnCenter(btnCenter), .btnTop(btnTop), .btnBottom(btnBottom),
      .btnLeft(btnLeft), .btnRight(btnRight),
      .sw(sw), .ssSel(ssSel), .ssDisp(ssDisp), .led(led)
   );

   always #5 clk = ~clk;

   localparam int DB = 16;  // blank digit
   localparam int DD = 17;  // dash digit
   localparam logic [4:0] K_N = 5'b00000;
   localparam logic [4:0] K_C = 5'b10000;
   localparam logic [4:0] K_T = 5'b01000;
   localparam logic [4:0] K_L = 5'b00100;
   localparam logic [4:0] K_R = 5'b00010;
   localparam logic [4:0] K_B = 5'b00001;

   typedef struct {
      string       name;
      logic [4:0]  btn;
      logic [15:0] sw;
      int          e0, e1, e2, e3;
      logic [15:0] led;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] disp;
      logic [15:0] led;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[$];
   int   total  = 0;
   int   passed = 0;
   int   m_round, m_win, m_lose;

   function automatic logic [7:0] seg(input int s);
      case (s)
         0: return 8'hC0;   1: return 8'hF9;   2: return 8'hA4;   3: return 8'hB0;
         4: return 8'h99;   5: return 8'h92;   6: return 8'h82;   7: return 8'hF8;
         8: return 8'h80;   9: return 8'h90;  10: return 8'h88;  11: return 8'h83;
        12: return 8'hC6;  13: return 8'hA1;  14: return 8'h86;  15: return 8'h8E;
        DD: return 8'hBF;
        default: return 8'hFF;
      endcase
   endfunction

   function automatic vec_t mk(input string n, input logic [4:0] b, input logic [15:0] s,
                               input int a0, input int a1, input int a2, input int a3,
                               input logic [15:0] l);
      vec_t v;
      v.name = n; v.btn = b; v.sw = s;
      v.e0 = a0; v.e1 = a1; v.e2 = a2; v.e3 = a3; v.led = l;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic expect_screen(input string n, input int a0, input int a1, input int a2,
                                input int a3, input logic [15:0] l);
      exp_t e;
      e.name = n;
      e.disp = {seg(a0), seg(a1), seg(a2), seg(a3)};
      e.led  = l;
      sbq.push_back(e);
   endtask

   task automatic set_btns(input logic [4:0] m);
      {btnCenter, btnTop, btnLeft, btnRight, btnBottom} = m;
   endtask

   task automatic press(input logic [4:0] m);
      @(negedge clk);
      set_btns(m);
      @(negedge clk);
      set_btns(K_N);
      repeat (2) @(negedge clk);
   endtask

   // Capture one full scan of the four digits, then compare against the queue head
   task automatic observe();
      logic [7:0] got [4];
      exp_t e;
      for (int k = 0; k < 4; k++) got[k] = 8'h00;
      repeat (16) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (ssSel[k] === 1'b0) got[k] = ssDisp;
      end
      if (sbq.size() == 0) begin
         total++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = sbq.pop_front();
         check({e.name, "_disp"}, {got[0], got[1], got[2], got[3]}, e.disp);
         check({e.name, "_led"}, {16'h0, led}, {16'h0, e.led});
      end
   endtask

   task automatic play_round(input int c1, input int c2);
      logic [15:0] el;
      logic        f;
      int          mc, gc;
      press(K_T);
      press(K_L);
      sw = 16'h0001 << (7 + c1);
      press(K_T);
      press(K_R);
      sw = 16'h0001 << (7 + c2);
      press(K_T);
      sw = '0;
      press(K_C);
      m_round = (m_round < 15) ? m_round + 1 : 15;
      if (c1 > c2) m_win++;
      if (c2 > c1) m_lose++;
      mc = (c1 > c2) ? 1 : (c2 > c1) ? 2 : 0;
      f  = (m_win >= 5) || (m_lose >= 5) || (m_round >= 9);
      el = '0;
      el[0] = f;
      el[1] = (c1 % 2 == 1);
      el[2] = (c2 % 2 == 1);
      expect_screen($sformatf("match_r%0d", m_round), mc, DB, DB, DB, el);
      observe();
      press(K_L);
      if (f) begin
         gc = (m_win > m_lose) ? 1 : (m_lose > m_win) ? 2 : 0;
         expect_screen($sformatf("game_r%0d", m_round), gc, DB, m_win, m_lose, el);
      end else begin
         expect_screen($sformatf("rasp_r%0d", m_round), m_round, DB, m_win, m_lose, el);
      end
      observe();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:3] es;
      resetn = 1'b0;
      sw     = '0;
      set_btns(K_N);
      #3;
      es = 4'b0111;
      check("rst_sel", {28'h0, ssSel}, {28'h0, es});
      check("rst_seg", {24'h0, ssDisp}, {24'h0, 8'hBF});
      check("rst_led", {16'h0, led}, 32'h0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      vecs.push_back(mk("init",       K_N,       16'h0000, DD, DD, DD, DD, 16'h0000));
      vecs.push_back(mk("init_bot",   K_B,       16'h0000, DD, DD, DD, DD, 16'h0000));
      vecs.push_back(mk("to_rasp",    K_C,       16'h0000,  0, DB,  0,  0, 16'h0000));
      vecs.push_back(mk("to_bawp",    K_T,       16'h0000,  0, DB,  0,  0, 16'h0000));
      vecs.push_back(mk("lr_p1",      K_L | K_R, 16'h0000,  1, DB, DB, DD, 16'hFF80));
      vecs.push_back(mk("p1_zero",    K_T,       16'h0000,  1, DB, DB, DD, 16'hFF80));
      vecs.push_back(mk("p1_c8",      K_T,       16'h8000,  0, DB,  0,  0, 16'h0000));
      vecs.push_back(mk("p1_locked",  K_L,       16'h0000,  0, DB,  0,  0, 16'h0000));
      vecs.push_back(mk("to_p2",      K_R,       16'h8000,  2, DB, DB,  8, 16'hFF80));
      vecs.push_back(mk("p2_twohot",  K_T,       16'hC000,  2, DB, DB, DD, 16'hFF80));
      vecs.push_back(mk("p2_c8",      K_T,       16'h8000,  0, DB,  0,  0, 16'h0000));
      vecs.push_back(mk("match_draw", K_C,       16'h0000,  0, DB, DB, DB, 16'h0000));
      vecs.push_back(mk("rasp_r1",    K_L,       16'h0000,  1, DB,  0,  0, 16'h0000));
      vecs.push_back(mk("bawp_r1",    K_T,       16'h0000,  1, DB,  0,  0, 16'h0000));
      vecs.push_back(mk("p1_show8",   K_L,       16'h8000,  1, DB, DB,  8, 16'h7F80));
      vecs.push_back(mk("p1_reuse8",  K_T,       16'h8000,  1, DB, DB,  8, 16'h7F80));
      vecs.push_back(mk("p1_c7",      K_T,       16'h4000,  1, DB,  0,  0, 16'h0002));
      vecs.push_back(mk("ctr_1lock",  K_C,       16'h0000,  1, DB,  0,  0, 16'h0002));
      vecs.push_back(mk("p2_show6",   K_R,       16'h2000,  2, DB, DB,  6, 16'h7F82));
      vecs.push_back(mk("p2_c6",      K_T,       16'h2000,  1, DB,  0,  0, 16'h0002));
      vecs.push_back(mk("match_p1",   K_C,       16'h0000,  1, DB, DB, DB, 16'h0002));
      vecs.push_back(mk("match_bot",  K_B,       16'h0000,  1, DB, DB, DB, 16'h0002));
      vecs.push_back(mk("rasp_r2",    K_L,       16'h0000,  2, DB,  1,  0, 16'h0002));

      foreach (vecs[i]) begin
         sw = vecs[i].sw;
         if (vecs[i].btn != K_N) press(vecs[i].btn);
         else @(negedge clk);
         expect_screen(vecs[i].name, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].led);
         observe();
      end

      // Game 1 continues to the round limit with P1 slightly ahead
      m_round = 2; m_win = 1; m_lose = 0;
      play_round(6, 5);
      play_round(5, 7);
      play_round(4, 4);
      play_round(3, 3);
      play_round(2, 2);
      play_round(1, 1);
      play_round(0, 0);
      press(K_B);
      expect_screen("game1_clr", DD, DD, DD, DD, 16'h0000);
      observe();

      // Game 2: P1 reaches the win target
      m_round = 0; m_win = 0; m_lose = 0;
      press(K_C);
      expect_screen("g2_rasp", 0, DB, 0, 0, 16'h0000);
      observe();
      play_round(8, 4);
      play_round(7, 3);
      play_round(6, 2);
      play_round(5, 1);
      play_round(4, 0);
      press(K_B);
      press(K_C);
      press(K_T);
      sw = '0;
      press(K_L);
      expect_screen("g3_p1_fresh", 1, DB, DB, DD, 16'hFF80);
      observe();

      // A held button must pulse once: a valid card appearing while held is not taken
      @(negedge clk);
      btnTop = 1'b1;
      repeat (3) @(negedge clk);
      sw = 16'h0200;
      repeat (3) @(negedge clk);
      expect_screen("held_top", 1, DB, DB, 2, 16'hFF80);
      observe();
      btnTop = 1'b0;
      sw = 16'h1000;
      press(K_T);
      expect_screen("p1_c5", 0, DB, 0, 0, 16'h0002);
      observe();

      // Asynchronous reset mid-round, checked between clock edges
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("async_led", {16'h0, led}, 32'h0);
      check("async_sel", {28'h0, ssSel}, {28'h0, es});
      check("async_seg", {24'h0, ssDisp}, {24'h0, 8'hBF});
      @(negedge clk);
      resetn = 1'b1;
      expect_screen("post_rst", DD, DD, DD, DD, 16'h0000);
      observe();
      press(K_C);
      press(K_T);
      expect_screen("post_rst_bawp", 0, DB, 0, 0, 16'h0000);
      observe();
      press(K_L);
      expect_screen("post_rst_p1", 1, DB, DB, 5, 16'hFF80);
      observe();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
